// File: rtl/s_cpu_pkg.sv
// SPC700 CPU shared definitions: PSW flag indices, mismatch-log entry type and the
// architectural cycle reference used by the instruction-timing monitor.
package s_cpu_pkg;

    localparam int unsigned PSW_C = 0;
    localparam int unsigned PSW_Z = 1;
    localparam int unsigned PSW_V = 6;
    localparam int unsigned PSW_N = 7;

    // meas travels beside this struct because its width follows CTR_W
    typedef struct packed {
        logic [7:0] op;
        logic [3:0] exp;
    } s_cpu_cycle_log_t;

    // Returns {exp, cond2}; cond2 marks opcodes that may also take exp+2 cycles.
    function automatic logic [4:0] s_cpu_cycle_ref(input logic [7:0] op, input logic [7:0] psw);
        logic [3:0] hi;
        logic [3:0] lo;
        logic [3:0] exp;
        logic       cond2;
        logic       flag;
        hi    = op[7:4];
        lo    = op[3:0];
        exp   = 4'd0;
        cond2 = 1'b0;
        unique case (hi[3:2])
            2'b11:   flag = psw[PSW_Z];
            2'b10:   flag = psw[PSW_C];
            2'b01:   flag = psw[PSW_V];
            default: flag = psw[PSW_N];
        endcase
        if (lo == 4'h0 && hi[0]) begin
            // odd rows of column 0 are Bcc; hi[1] is the flag value that takes the branch
            exp = (flag == hi[1]) ? 4'd4 : 4'd2;
        end else if (lo == 4'h1) begin
            exp = 4'd8;
        end else if (lo == 4'h2) begin
            exp = 4'd4;
        end else if (lo == 4'h3) begin
            exp   = 4'd5;
            cond2 = 1'b1;
        end else if (lo >= 4'h4 && lo <= 4'h9 && hi <= 4'hB) begin
            case (lo)
                4'h4:    exp = hi[0] ? 4'd4 : 4'd3;
                4'h5:    exp = hi[0] ? 4'd5 : 4'd4;
                4'h6:    exp = hi[0] ? 4'd5 : 4'd3;
                4'h7:    exp = 4'd6;
                4'h8:    exp = hi[0] ? 4'd5 : 4'd2;
                default: exp = hi[0] ? 4'd5 : 4'd6;
            endcase
        end else if (lo == 4'hB && hi <= 4'hD) begin
            exp = hi[0] ? 4'd5 : 4'd4;
        end else if (lo == 4'hC && hi <= 4'hD) begin
            exp = hi[0] ? 4'd2 : 4'd5;
        end else begin
            case (op)
                8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hE0, 8'hC8, 8'hE8, 8'h1D, 8'h3D, 8'h5D,
                8'h7D, 8'h8D, 8'h9D, 8'hAD, 8'hBD, 8'hCD, 8'hDD, 8'hFD, 8'hFC: exp = 4'd2;
                8'hA0, 8'hC0, 8'hE4, 8'hE6, 8'hF8, 8'hEB, 8'hED, 8'h3E, 8'h7E, 8'hBE, 8'h5F,
                8'hDF: exp = 4'd3;
                8'hC4, 8'hC6, 8'hD8, 8'hE5, 8'hE9, 8'hF4, 8'hF9, 8'h4A, 8'h5A, 8'h6A, 8'hAA,
                8'hFB, 8'hEC, 8'h0D, 8'h2D, 8'h4D, 8'h6D, 8'h1E, 8'h5E, 8'h8E, 8'hAE, 8'hCE,
                8'hEE, 8'hFE, 8'h2F, 8'hAF, 8'hBF: exp = 4'd4;
                8'hC5, 8'hC9, 8'hD4, 8'hD9, 8'hF5, 8'hF6, 8'h0A, 8'h2A, 8'h7A, 8'h8A, 8'h9A,
                8'hBA, 8'hDA, 8'hEA, 8'hFA, 8'h2E, 8'h6E, 8'h6F, 8'h8F, 8'h9F: exp = 4'd5;
                8'hD5, 8'hD6, 8'hE7, 8'hF7, 8'h1A, 8'h3A, 8'hCA, 8'h0E, 8'h4E, 8'hDE, 8'h1F,
                8'h4F, 8'h7F: exp = 4'd6;
                8'hC7, 8'hD7: exp = 4'd7;
                8'h0F, 8'h3F: exp = 4'd8;
                8'hCF:        exp = 4'd9;
                8'h9E:        exp = 4'd12;
                default:      exp = 4'd0;  // SLEEP/STOP never retire normally
            endcase
            cond2 = (op == 8'h2E) || (op == 8'h6E) || (op == 8'hDE) || (op == 8'hFE);
        end
        return {exp, cond2};
    endfunction

endpackage

// File: rtl/s_cpu_cycle_log_fifo.sv
// Show-ahead FIFO for the cycle-monitor mismatch log; head entry is visible while valid.
module s_cpu_cycle_log_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so equal indices can mean empty or full
    assign valid   = wr_ptr_q != rd_ptr_q;
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/s_cpu_cycle_monitor.sv
// Passive SPC700 instruction-timing monitor: measures each retired instruction's cycles.
// Define S_CPU_CYCLE_MON_LOG_EN to build the mismatch log; otherwise log_* outputs read 0.
module s_cpu_cycle_monitor
    import s_cpu_pkg::*;
#(
    parameter int unsigned CTR_W     = 5,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned LOG_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_en,
    input  logic             state_opfetch,
    input  logic [7:0]       op,
    input  logic [7:0]       psw,
    input  logic             mon_en,
    input  logic             clear,
    input  logic             log_rd,
    output logic             log_valid,
    output logic [7:0]       log_op,
    output logic [CTR_W-1:0] log_meas,
    output logic [3:0]       log_exp,
    output logic             log_overflow,
    output logic             err_sticky,
    output logic [7:0]       first_err_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] err_count
);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam int unsigned      CMP_W   = (CTR_W > 5) ? CTR_W : 5;

    logic             retire;
    logic             armed_q;
    logic [CTR_W-1:0] cyc_ctr_q;
    logic [7:0]       op_reg_q;
    logic [CTR_W-1:0] meas;
    logic [3:0]       ref_exp;
    logic             ref_cond2;
    logic [CMP_W-1:0] meas_x;
    logic [CMP_W-1:0] exp_x;
    logic             checked;
    logic             mismatch;

    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_sticky_q, err_sticky_d;
    logic [7:0]       first_err_op_q, first_err_op_d;

    assign retire             = cpu_en & state_opfetch;
    assign {ref_exp, ref_cond2} = s_cpu_cycle_ref(op_reg_q, psw);
    assign meas               = (cyc_ctr_q == CTR_MAX) ? CTR_MAX : cyc_ctr_q + 1'b1;
    assign meas_x             = CMP_W'(meas);
    assign exp_x              = CMP_W'(ref_exp);
    assign checked            = retire & armed_q & mon_en & (ref_exp != 4'd0);
    // A saturated count is a hang and never matches, whatever the reference says
    assign mismatch = checked & ((meas == CTR_MAX) |
                      ((meas_x != exp_x) & ~(ref_cond2 & (meas_x == exp_x + CMP_W'(2)))));

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_ctr_q <= '0;
            op_reg_q  <= '0;
            armed_q   <= 1'b0;
        end else if (retire) begin
            cyc_ctr_q <= '0;
            op_reg_q  <= op;
            armed_q   <= 1'b1;
        end else if (cpu_en && cyc_ctr_q != CTR_MAX) begin
            cyc_ctr_q <= cyc_ctr_q + 1'b1;
        end
    end

    always_comb begin
        instr_count_d  = instr_count_q;
        err_count_d    = err_count_q;
        err_sticky_d   = err_sticky_q;
        first_err_op_d = first_err_op_q;
        if (clear) begin
            instr_count_d  = '0;
            err_count_d    = '0;
            err_sticky_d   = 1'b0;
            first_err_op_d = '0;
        end else if (checked) begin
            if (instr_count_q != '1) instr_count_d = instr_count_q + 1'b1;
            if (mismatch) begin
                if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
                err_sticky_d = 1'b1;
                if (!err_sticky_q) first_err_op_d = op_reg_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count_q  <= '0;
            err_count_q    <= '0;
            err_sticky_q   <= 1'b0;
            first_err_op_q <= '0;
        end else begin
            instr_count_q  <= instr_count_d;
            err_count_q    <= err_count_d;
            err_sticky_q   <= err_sticky_d;
            first_err_op_q <= first_err_op_d;
        end
    end

    assign instr_count  = instr_count_q;
    assign err_count    = err_count_q;
    assign err_sticky   = err_sticky_q;
    assign first_err_op = first_err_op_q;

`ifdef S_CPU_CYCLE_MON_LOG_EN
    localparam int unsigned LOG_W = $bits(s_cpu_cycle_log_t) + CTR_W;

    s_cpu_cycle_log_t log_entry;
    s_cpu_cycle_log_t log_head;
    logic [CTR_W-1:0] log_head_meas;
    logic [LOG_W-1:0] log_wdata;
    logic [LOG_W-1:0] log_rdata;
    logic             log_push;
    logic             log_nonempty;
    logic             log_full;
    logic             log_overflow_q, log_overflow_d;

    assign log_entry = '{op: op_reg_q, exp: ref_exp};
    assign log_wdata = {log_entry, meas};
    assign log_push  = mismatch & ~clear;

    s_cpu_cycle_log_fifo #(
        .DEPTH(LOG_DEPTH),
        .WIDTH(LOG_W)
    ) u_log_fifo (
        .clk  (clk),
        .reset(reset),
        .flush(clear),
        .push (log_push),
        .pop  (log_rd),
        .wdata(log_wdata),
        .rdata(log_rdata),
        .valid(log_nonempty),
        .full (log_full)
    );

    assign {log_head, log_head_meas} = log_rdata;

    // A simultaneous pop frees the slot, so only an unpaired push into a full log is lost
    always_comb begin
        log_overflow_d = log_overflow_q;
        if (clear) begin
            log_overflow_d = 1'b0;
        end else if (log_push && log_full && !log_rd) begin
            log_overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            log_overflow_q <= 1'b0;
        end else begin
            log_overflow_q <= log_overflow_d;
        end
    end

    assign log_valid    = log_nonempty;
    assign log_op       = log_nonempty ? log_head.op : '0;
    assign log_exp      = log_nonempty ? log_head.exp : '0;
    assign log_meas     = log_nonempty ? log_head_meas : '0;
    assign log_overflow = log_overflow_q;
`else
    logic unused_log_rd;
    assign unused_log_rd = log_rd;
    assign log_valid     = 1'b0;
    assign log_op        = '0;
    assign log_meas      = '0;
    assign log_exp       = '0;
    assign log_overflow  = 1'b0;
`endif

endmodule

// File: doc/s_cpu_cycle_monitor.md
# s_cpu_cycle_monitor

Parametrised SPC700 instruction-timing monitor in the APU CPU controller. It measures the cycle count of every retired instruction, including taken and not-taken branches, against the architectural reference count. It keeps saturating pass and fail statistics, plus a first-failure capture. Optionally it logs each mismatch into a small show-ahead FIFO that a debug reader drains. It is a passive observer: no output feeds back into the CPU.

## Interface
Parameters:
- CTR_W, 5: cycle-counter width; the saturation value is 2^CTR_W-1.
- CNT_W, 16: width of the instruction and error statistics counters.
- LOG_DEPTH, 8: mismatch-log depth; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cpu_en  in  1  CPU clock-enable. All tracking advances only when it is 1.
- state_opfetch  in  1  CPU is in its opcode-fetch cycle.
- op  in  8  opcode bus, valid in the fetch cycle.
- psw  in  8  processor status word; flag indices come from s_cpu_pkg.
- mon_en  in  1  enables checking. When 0, the cycle counter still runs, but no checks, counts or log pushes occur.
- clear  in  1  zeroes statistics, sticky flags, first-error capture and the log.
- log_rd  in  1  pop the log head; ignored when the log is empty.
- log_valid  out  1  log is non-empty.
- log_op  out  8  opcode of the head entry.
- log_meas  out  CTR_W  measured cycles of the head entry.
- log_exp  out  4  expected base cycles of the head entry.
- log_overflow  out  1  sticky: at least one mismatch was dropped because the log was full.
- err_sticky  out  1  sticky: at least one mismatch has occurred.
- first_err_op  out  8  opcode of the first mismatch since reset or clear.
- instr_count  out  CNT_W  checked instructions, saturating.
- err_count  out  CNT_W  mismatches, saturating.

## Operation
- **Retire event.** Occurs on any edge where cpu_en & state_opfetch = 1. At that edge:
  - op_reg <= op.
  - cyc_ctr <= 0.
- **Counting.** On other cpu_en edges, cyc_ctr increments and saturates at its maximum value.
- **Measured count.** meas = cyc_ctr+1 at the retire edge. When cyc_ctr is saturated, meas = the saturation value.
- **Expected count.** {exp, cond2} = s_cpu_cycle_ref(op_reg, psw).
  - Conditional branches F0/D0/B0/90/70/50/30/10 take 4 cycles if taken, else 2.
  - BBS/BBC (x3) and CBNE/DBNZ (2E/DE/6E/FE) set cond2. They accept exp or exp+2.
  - exp = 0 means unchecked: no count, no error.
- **Mismatch.** Raised when all of the following hold:
  - checking is armed;
  - exp != 0;
  - meas != exp;
  - not (cond2 & meas == exp+2).
  - A saturated meas always mismatches (hang detection).
- **Arming.** Reset disarms checking. The first retire event after reset arms it and performs no check. This applies equally to a reset that arrives mid-instruction.
- **Checked event.** A retire event that is armed, has mon_en = 1 and exp != 0.
  - instr_count is incremented.
  - On mismatch, err_count is incremented and err_sticky is set.
  - If err_sticky was 0, first_err_op <= op_reg.
  - The entry {op_reg, meas, exp} is pushed to the log.
- **Log.**
  - The log is a show-ahead FIFO; the head entry is visible whenever log_valid = 1.
  - A push to a full log drops the entry and sets log_overflow.
  - A push and a pop in the same edge on a full log both take effect, and log_overflow is not set.
  - A pop from an empty log is ignored.
  - Pointers wrap modulo LOG_DEPTH, with one extra bit used to distinguish full from empty.
- **Clear.** clear has priority over a simultaneous checked event, and that event is discarded entirely. clear does not affect cyc_ctr, op_reg or arming.
- **Reset values.** All outputs are 0, including log_valid. cyc_ctr = 0, op_reg = 0, and checking is disarmed.

## Timing
- All outputs are registered.
- Statistics, the sticky flags and first_err_op update on the retire edge, so they are visible in the following cycle.
- The log entry is visible on log_* in the cycle after the push edge, provided the log was empty.
- Pop latency is one edge: the next entry appears in the cycle after the log_rd edge.
- cpu_en = 0 freezes all tracking. clear and log_rd are honoured regardless of cpu_en.

## Configuration
- S_CPU_CYCLE_MON_LOG_EN defined: the mismatch log is built as described above.
- Not defined: no FIFO is instantiated. log_valid, log_op, log_meas, log_exp and log_overflow are tied to 0, and log_rd is ignored. The statistics counters and first-error capture are unchanged.

## Structure
- s_cpu_pkg gains:
  - function s_cpu_cycle_ref(op, psw) returning {exp[3:0], cond2}, covering all 256 opcodes;
  - typedef s_cpu_cycle_log_t {op, exp}, with meas carried alongside because its width is CTR_W.
- The existing Z/C/V/N flag indices in s_cpu_pkg are reused.
- One sub-module: s_cpu_cycle_log_fifo, parametrised by depth and width, with ports push, pop, wdata, rdata, valid, full.

## Test plan
- **Reset and first retire.** Reset, then opfetch E8 with 2 cycles, then opfetch 00. Expected: the first opfetch is unchecked; instr_count = 1, err_count = 0.
- **Branch timing.** BEQ (F0) with psw[Z] = 1 retiring after 4 cycles passes. Z = 1 retiring after 2 cycles gives err_count = 1 and log {F0, 2, 4}.
- **cond2 opcodes.** DBNZ Y (FE) retiring after 4 cycles and after 6 cycles both pass. Retiring after 5 cycles gives a mismatch with log_exp = 4.
- **Log overflow.** 9 mismatches with LOG_DEPTH = 8 and no reads: log_overflow = 1 and err_count = 9. Draining yields the first 8 entries in order, then log_valid = 0.
- **Hang detection.** No opfetch for 40 cycles with CTR_W = 5: meas = 31, a mismatch is logged, and first_err_op = op_reg.
- **Clear versus mismatch.** clear asserted on the same edge as a mismatching retire: all statistics are 0 afterwards, log_valid = 0, and the next retire is checked normally.
